load_store_unit: RTL and testbench

- Sits directly upstream of the byte-wide data memory and is the CPU datapath's only path to it.
- Converts byte, halfword and word load/store requests into sequential one-byte-per-cycle memory accesses. Byte order is little-endian.
- Handles sign and zero extension and alignment/range checking.
- Uses a Req/Busy/Done handshake so the control unit can stall while an access is in progress.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into one-byte-per-cycle
// accesses on a byte-wide data memory with registered reads (little-endian).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for Req; illegal requests pulse Err
// LOAD      | issuing load addresses, capturing bytes two edges later
// LOAD_LAST | last address issued; capture final byte, update RdData
// STORE     | driving one write byte per cycle
module load_store_unit #(
  parameter int AW = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Ad,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [31:0] RdData,
  output logic [31:0] MemAd,
  output logic [7:0]  MemWrData,
  output logic        MemWr,
  input  logic [7:0]  MemRdData
);

  typedef enum logic [1:0] {IDLE, LOAD, LOAD_LAST, STORE} state_t;

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;
  logic [1:0]    sz_q, sz_n;
  logic          se_q, se_n;
  logic [31:0]   wd_q, wd_n;
  logic [31:0]   asm_q, asm_n;
  logic [AW-1:0] ad_q, ad_n;
  logic          busy_n, done_n, err_n, mwr_n;
  logic [31:0]   rd_n;
  logic [7:0]    mwd_n;
  logic [1:0]    last_idx;
  logic [31:0]   word;
  logic          misalign, out_of_range, illegal;

  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0]  sz,
                                         input logic        se);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{se & w[7]}}, w[7:0]};
      2'b01:   r = {{16{se & w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign misalign     = (Size == 2'b01 && Ad[0]) || (Size == 2'b10 && Ad[1:0] != 2'b00);
  assign out_of_range = |Ad[31:AW];
  assign illegal      = (Size == 2'b11) || misalign || out_of_range;

  // Aligned requests never carry past AW bits, so only the low bits are kept.
  assign MemAd = {{(32-AW){1'b0}}, ad_q};

  always_comb begin
    case (sz_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      sz_q      <= 2'b00;
      se_q      <= 1'b0;
      wd_q      <= 32'h0;
      asm_q     <= 32'h0;
      ad_q      <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      RdData    <= 32'h0;
      MemWrData <= 8'h0;
      MemWr     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sz_q      <= sz_n;
      se_q      <= se_n;
      wd_q      <= wd_n;
      asm_q     <= asm_n;
      ad_q      <= ad_n;
      Busy      <= busy_n;
      Done      <= done_n;
      Err       <= err_n;
      RdData    <= rd_n;
      MemWrData <= mwd_n;
      MemWr     <= mwr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sz_n    = sz_q;
    se_n    = se_q;
    wd_n    = wd_q;
    asm_n   = asm_q;
    ad_n    = ad_q;
    busy_n  = Busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rd_n    = RdData;
    mwd_n   = 8'h0;
    mwr_n   = 1'b0;
    word    = asm_q;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (Req) begin
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            sz_n   = Size;
            se_n   = SignExt;
            cnt_n  = 2'd0;
            ad_n   = Ad[AW-1:0];
            busy_n = 1'b1;
            if (We) begin
              mwr_n   = 1'b1;
              mwd_n   = WrData[7:0];
              wd_n    = {8'h00, WrData[31:8]};
              state_n = STORE;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end

      LOAD: begin
        // Byte cnt-1 was addressed two edges ago and is on MemRdData now.
        if (cnt != 2'd0)
          asm_n = put_byte(asm_q, cnt - 2'd1, MemRdData);
        if (cnt == last_idx) begin
          state_n = LOAD_LAST;
        end else begin
          cnt_n = cnt + 2'd1;
          ad_n  = ad_q + AW'(1);
        end
      end

      LOAD_LAST: begin
        word    = put_byte(asm_q, cnt, MemRdData);
        asm_n   = word;
        rd_n    = extend(word, sz_q, se_q);
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      STORE: begin
        if (cnt == last_idx) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 2'd1;
          ad_n  = ad_q + AW'(1);
          mwr_n = 1'b1;
          mwd_n = wd_q[7:0];
          wd_n  = {8'h00, wd_q[31:8]};
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, directed table, back-to-back
// and reset-abort sequences, then random requests against a reference model.
module tb_load_store_unit;

  logic        Clk, Reset, Req, We, SignExt;
  logic [1:0]  Size;
  logic [31:0] Ad, WrData;
  logic        Busy, Done, Err, MemWr;
  logic [31:0] RdData, MemAd;
  logic [7:0]  MemWrData, MemRdData;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [64];
  logic [7:0] init_img [64];
  logic [7:0] ref_mem [64];
  logic       init_en;
  logic [31:0] model_rd;

  load_store_unit #(.AW(6)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Size(Size),
    .SignExt(SignExt), .Ad(Ad), .WrData(WrData), .Busy(Busy), .Done(Done),
    .Err(Err), .RdData(RdData), .MemAd(MemAd), .MemWrData(MemWrData),
    .MemWr(MemWr), .MemRdData(MemRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Byte-wide memory with registered read.
  always @(posedge Clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
    end else if (MemWr) begin
      mem[MemAd[5:0]] <= MemWrData;
    end
    MemRdData <= mem[MemAd[5:0]];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        se;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_done;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request starting at a negedge and observes 8 cycles.
  // exp_done = cycle (after accept) carrying Done; 0 means an Err request.
  task automatic run_op(input logic we, input logic [1:0] size, input logic se,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_done, input string tag);
    logic [7:0]  ob, od, oe, ow, eb, ed, ee, ew;
    logic [31:0] oad [8];
    logic [7:0]  owd [8];
    int n;
    n = (size == 2'b11) ? 0 : (1 << size);
    Req = 1'b1; We = we; Size = size; SignExt = se; Ad = ad; WrData = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      ob[c-1] = Busy; od[c-1] = Done; oe[c-1] = Err; ow[c-1] = MemWr;
      oad[c-1] = MemAd; owd[c-1] = MemWrData;
      eb[c-1] = (exp_done != 0) && (c < exp_done);
      ed[c-1] = (exp_done != 0) && (c == exp_done);
      ee[c-1] = (exp_done == 0) && (c == 1);
      ew[c-1] = we && (exp_done != 0) && (c < exp_done);
      if (c == 1) Req = 1'b0;
    end
    check({tag, " busy"}, 64'(ob), 64'(eb));
    check({tag, " done"}, 64'(od), 64'(ed));
    check({tag, " err"},  64'(oe), 64'(ee));
    check({tag, " memwr"}, 64'(ow), 64'(ew));
    if (exp_done != 0) begin
      for (int k = 0; k < n; k++) begin
        check($sformatf("%s memad%0d", tag, k), 64'(oad[k]), 64'(ad + k));
        if (we) check($sformatf("%s wdata%0d", tag, k), 64'(owd[k]), 64'(wd[8*k +: 8]));
      end
      if (we) for (int k = 0; k < n; k++) ref_mem[ad[5:0] + k] = wd[8*k +: 8];
    end
    check({tag, " rddata"}, 64'(RdData), 64'(exp_rd));
    model_rd = exp_rd;
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic se,
                       input logic [31:0] ad, output logic [31:0] rd, output int dn);
    int n;
    logic [31:0] v, mask;
    n = (size == 2'b11) ? 0 : (1 << size);
    rd = model_rd;
    dn = 0;
    if (n == 0 || (ad % n) != 0 || ad >= 64) return;
    if (we) begin
      dn = n + 1;
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v |= 32'(ref_mem[ad + k]) << (8 * k);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
      if (se && v[8*n-1]) v |= ~mask;
      rd = v;
      dn = n + 2;
    end
  endtask

  initial begin
    logic [13:0] ob, od, ow, eb, ed, ew;
    logic [31:0] oad [14];
    logic [7:0]  owd [14];
    logic        saw_done;
    logic [31:0] erd, rad, rwd;
    logic [1:0]  rsz;
    logic        rwe, rse;
    int          edn, r;

    for (int i = 0; i < 64; i++) begin
      init_img[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    init_img[8] = 8'h11; init_img[9] = 8'h22; init_img[10] = 8'h83; init_img[11] = 8'h44;
    ref_mem[8]  = 8'h11; ref_mem[9]  = 8'h22; ref_mem[10]  = 8'h83; ref_mem[11]  = 8'h44;
    init_en = 1'b1;
    model_rd = 32'h0;
    Reset = 1'b1; Req = 1'b0; We = 1'b0; Size = 2'b00; SignExt = 1'b0;
    Ad = 32'h0; WrData = 32'h0;

    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'd8,  32'h0,        32'h44832211, 6};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'd10, 32'h0,        32'hFFFFFF83, 3};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'd10, 32'h0,        32'h00000083, 3};
    tbl[3]  = '{1'b0, 2'b01, 1'b1, 32'd10, 32'h0,        32'h00004483, 4};
    tbl[4]  = '{1'b1, 2'b01, 1'b0, 32'd4,  32'hAABBCCDD, 32'h00004483, 3};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'd4,  32'h0,        32'hFFFFCCDD, 4};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'd6,  32'h0,        32'hFFFFCCDD, 0};
    tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'd3,  32'h0,        32'hFFFFCCDD, 0};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'd0,  32'h0,        32'hFFFFCCDD, 0};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        32'hFFFFCCDD, 0};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h80000008, 32'h5A, 32'hFFFFCCDD, 0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 32'd60, 32'h12345678, 32'hFFFFCCDD, 5};
    tbl[12] = '{1'b0, 2'b10, 1'b1, 32'd60, 32'h0,        32'h12345678, 6};
    tbl[13] = '{1'b0, 2'b01, 1'b0, 32'd62, 32'h0,        32'h00001234, 4};
    tbl[14] = '{1'b0, 2'b00, 1'b1, 32'd63, 32'h0,        32'h00000012, 3};
    tbl[15] = '{1'b0, 2'b01, 1'b1, 32'd60, 32'h0,        32'h00005678, 4};
    tbl[16] = '{1'b1, 2'b00, 1'b0, 32'd5,  32'h000000F0, 32'h00005678, 2};
    tbl[17] = '{1'b0, 2'b01, 1'b1, 32'd4,  32'h0,        32'hFFFFF0DD, 4};

    repeat (3) @(negedge Clk);
    check("reset busy",  64'(Busy), 64'(0));
    check("reset done",  64'(Done), 64'(0));
    check("reset err",   64'(Err), 64'(0));
    check("reset memwr", 64'(MemWr), 64'(0));
    check("reset memad", 64'(MemAd), 64'(0));
    check("reset wdata", 64'(MemWrData), 64'(0));
    check("reset rd",    64'(RdData), 64'(0));
    init_en = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 18; i++)
      run_op(tbl[i].we, tbl[i].size, tbl[i].se, tbl[i].ad, tbl[i].wd,
             tbl[i].exp_rd, tbl[i].exp_done, $sformatf("tbl%0d", i));

    // Req held high: LW 8 then SW 16 accepted at the edge ending the LW Done cycle.
    Req = 1'b1; We = 1'b0; Size = 2'b10; SignExt = 1'b0; Ad = 32'd8; WrData = 32'h0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      ob[c-1] = Busy; od[c-1] = Done; ow[c-1] = MemWr;
      oad[c-1] = MemAd; owd[c-1] = MemWrData;
      eb[c-1] = (c <= 5) || (c >= 7 && c <= 10);
      ed[c-1] = (c == 6) || (c == 11);
      ew[c-1] = (c >= 7 && c <= 10);
      if (c == 1) begin We = 1'b1; Ad = 32'd16; WrData = 32'hCAFEF00D; end
      if (c == 7) Req = 1'b0;
    end
    check("b2b busy",  64'(ob), 64'(eb));
    check("b2b done",  64'(od), 64'(ed));
    check("b2b memwr", 64'(ow), 64'(ew));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b ld memad%0d", k), 64'(oad[k]), 64'(8 + k));
      check($sformatf("b2b st memad%0d", k), 64'(oad[6+k]), 64'(16 + k));
      check($sformatf("b2b st wdata%0d", k), 64'(owd[6+k]), 64'(32'hCAFEF00D >> (8*k) & 32'hFF));
      ref_mem[16+k] = 8'(32'hCAFEF00D >> (8*k));
    end
    check("b2b rddata", 64'(RdData), 64'(32'h44832211));
    model_rd = 32'h44832211;
    run_op(1'b0, 2'b10, 1'b0, 32'd16, 32'h0, 32'hCAFEF00D, 6, "b2b readback");

    // Asynchronous reset in the middle of a word store.
    Req = 1'b1; We = 1'b1; Size = 2'b10; Ad = 32'd12; WrData = 32'hDEADBEEF;
    @(negedge Clk);
    Req = 1'b0;
    check("abort first memwr", 64'(MemWr), 64'(1));
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort memwr", 64'(MemWr), 64'(0));
    check("abort busy",  64'(Busy), 64'(0));
    saw_done = 1'b0;
    repeat (2) begin @(negedge Clk); saw_done |= Done; end
    Reset = 1'b0;
    repeat (3) begin @(negedge Clk); saw_done |= Done | Busy; end
    check("abort no done", 64'(saw_done), 64'(0));
    check("abort mem12", 64'(mem[12]), 64'(8'hEF));
    check("abort mem13", 64'(mem[13]), 64'(ref_mem[13]));
    check("abort mem14", 64'(mem[14]), 64'(ref_mem[14]));
    check("abort mem15", 64'(mem[15]), 64'(ref_mem[15]));
    check("abort rddata", 64'(RdData), 64'(0));
    ref_mem[12] = 8'hEF;
    model_rd = 32'h0;

    for (int i = 0; i < 250; i++) begin
      rsz = 2'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      rse = 1'($urandom_range(0, 1));
      rwd = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      rad = $urandom;
      else if (r == 1) rad = $urandom_range(0, 63);
      else if (rsz == 2'b11) rad = $urandom_range(0, 63);
      else rad = $urandom_range(0, 63) & ~((32'd1 << rsz) - 1);
      model(rwe, rsz, rse, rad, erd, edn);
      run_op(rwe, rsz, rse, rad, rwd, erd, edn, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
